pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 157 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard control for a 5-stage in-order pipeline: stalls, flushes, forwarding,
// memory-wait timeout and stall/flush performance counters.
// Ports:
//   clk, rst (async active-low)
//   validD, Rs1D, Rs2D, RdD, regWriteD, loadD, memAccD, luiD : decode slot
//   redirectE : taken branch/jump in Execute
//   memReady : data memory finishes the Memory-stage access this cycle
//   stallF/D/E/M, flushD/E : pipeline register controls
//   forwardAE/BE : operand selects (00 RF, 01 WB, 10 M ALU, 11 M lui)
//   memErr : sticky memory timeout; stallCnt/flushCnt : saturating counters
module pipe_hazard_ctrl #(
    parameter int REG_AW  = 5,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              validD,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] RdD,
    input  logic              regWriteD,
    input  logic              loadD,
    input  logic              memAccD,
    input  logic              luiD,
    input  logic              redirectE,
    input  logic              memReady,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              stallM,
    output logic              flushD,
    output logic              flushE,
    output logic [1:0]        forwardAE,
    output logic [1:0]        forwardBE,
    output logic              memErr,
    output logic [CNT_W-1:0]  stallCnt,
    output logic [CNT_W-1:0]  flushCnt
);

    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] TMAX = WW'(TIMEOUT);
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic              validE, regWriteE, loadE, memAccE, luiE;
    logic [REG_AW-1:0] rs1E, rs2E, rdE;
    logic              validM, regWriteM, memAccM, luiM;
    logic [REG_AW-1:0] rdM;
    logic              validW, regWriteW;
    logic [REG_AW-1:0] rdW;

    logic          memWait, loadUse, bubbleE;
    logic [WW-1:0] waitCnt, waitNext;

    assign memWait = validM & memAccM & ~memReady;
    assign loadUse = validE & loadE & (rdE != '0)
                   & ((rdE == Rs1D) | (rdE == Rs2D));
    // Redirect outranks load-use: the dependent instruction is squashed anyway.
    assign bubbleE = ~memWait & (redirectE | loadUse);

    // Outputs are forced quiet while reset is held, even if redirectE is high.
    assign stallF = rst & (memWait | (~redirectE & loadUse));
    assign stallD = stallF;
    assign stallE = rst & memWait;
    assign stallM = rst & memWait;
    assign flushD = rst & ~memWait & redirectE;
    assign flushE = rst & bubbleE;

    logic mHitA, mHitB, wHitA, wHitB;
    assign mHitA = validM & regWriteM & (rdM != '0) & (rdM == rs1E);
    assign mHitB = validM & regWriteM & (rdM != '0) & (rdM == rs2E);
    assign wHitA = validW & regWriteW & (rdW != '0) & (rdW == rs1E);
    assign wHitB = validW & regWriteW & (rdW != '0) & (rdW == rs2E);

    assign forwardAE = mHitA ? (luiM ? 2'b11 : 2'b10) : (wHitA ? 2'b01 : 2'b00);
    assign forwardBE = mHitB ? (luiM ? 2'b11 : 2'b10) : (wHitB ? 2'b01 : 2'b00);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            validE    <= 1'b0;
            regWriteE <= 1'b0;
            loadE     <= 1'b0;
            memAccE   <= 1'b0;
            luiE      <= 1'b0;
            rs1E      <= '0;
            rs2E      <= '0;
            rdE       <= '0;
            validM    <= 1'b0;
            regWriteM <= 1'b0;
            memAccM   <= 1'b0;
            luiM      <= 1'b0;
            rdM       <= '0;
        end else if (!memWait) begin
            if (bubbleE) begin
                validE    <= 1'b0;
                regWriteE <= 1'b0;
                loadE     <= 1'b0;
                memAccE   <= 1'b0;
                luiE      <= 1'b0;
            end else begin
                validE    <= validD;
                regWriteE <= validD & regWriteD;
                loadE     <= validD & loadD;
                memAccE   <= validD & memAccD;
                luiE      <= validD & luiD;
                rs1E      <= Rs1D;
                rs2E      <= Rs2D;
                rdE       <= RdD;
            end
            validM    <= validE;
            regWriteM <= regWriteE;
            memAccM   <= memAccE;
            luiM      <= luiE;
            rdM       <= rdE;
        end
    end

    // W takes a bubble while M is stuck waiting on memory.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            validW    <= 1'b0;
            regWriteW <= 1'b0;
            rdW       <= '0;
        end else if (memWait) begin
            validW    <= 1'b0;
            regWriteW <= 1'b0;
        end else begin
            validW    <= validM;
            regWriteW <= regWriteM;
            rdW       <= rdM;
        end
    end

    assign waitNext = !memWait ? '0
                    : (waitCnt == TMAX) ? waitCnt : waitCnt + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            waitCnt  <= '0;
            memErr   <= 1'b0;
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            waitCnt <= waitNext;
            if (waitNext == TMAX && memWait) begin
                memErr <= 1'b1;
            end
            if (stallF && stallCnt != CMAX) begin
                stallCnt <= stallCnt + 1'b1;
            end
            if (redirectE && !memWait && flushCnt != CMAX) begin
                flushCnt <= flushCnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl: forwarding, load-use, redirect,
// memory wait/timeout and asynchronous reset, with hand-computed expectations.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        validD;
    logic [4:0]  Rs1D, Rs2D, RdD;
    logic        regWriteD, loadD, memAccD, luiD;
    logic        redirectE, memReady;
    logic        stallF, stallD, stallE, stallM, flushD, flushE;
    logic [1:0]  forwardAE, forwardBE;
    logic        memErr;
    logic [15:0] stallCnt, flushCnt;

    int checks = 0;
    int errors = 0;

    pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(16), .TIMEOUT(2)) dut (
        .clk(clk), .rst(rst), .validD(validD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .regWriteD(regWriteD), .loadD(loadD), .memAccD(memAccD), .luiD(luiD),
        .redirectE(redirectE), .memReady(memReady),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .memErr(memErr), .stallCnt(stallCnt), .flushCnt(flushCnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic issue(input int rs1, input int rs2, input int rd,
                         input bit rw, input bit ld, input bit mem,
                         input bit lui);
        validD    = 1'b1;
        Rs1D      = 5'(rs1);
        Rs2D      = 5'(rs2);
        RdD       = 5'(rd);
        regWriteD = rw;
        loadD     = ld;
        memAccD   = mem;
        luiD      = lui;
    endtask

    task automatic nop();
        validD    = 1'b0;
        Rs1D      = '0;
        Rs2D      = '0;
        RdD       = '0;
        regWriteD = 1'b0;
        loadD     = 1'b0;
        memAccD   = 1'b0;
        luiD      = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        rst       = 1'b0;
        redirectE = 1'b1;
        memReady  = 1'b1;
        nop();
        repeat (2) step();
        settle();
        check("rst_stallF", stallF, 0);
        check("rst_flushD", flushD, 0);
        check("rst_flushE", flushE, 0);
        check("rst_fwdA", forwardAE, 0);
        check("rst_stallCnt", stallCnt, 0);
        check("rst_flushCnt", flushCnt, 0);
        check("rst_memErr", memErr, 0);

        redirectE = 1'b0;
        rst = 1'b1;
        step();

        // add x5, then two readers of x5
        issue(0, 0, 5, 1, 0, 0, 0);
        step();
        issue(5, 0, 0, 0, 0, 0, 0);
        step();
        settle();
        check("fwd_add_M", forwardAE, 2);
        check("fwd_add_nostall", stallF, 0);
        issue(5, 0, 0, 0, 0, 0, 0);
        step();
        settle();
        check("fwd_add_W", forwardAE, 1);
        nop();
        repeat (3) step();

        // load x7 then use in rs2
        issue(0, 0, 7, 1, 1, 1, 0);
        step();
        issue(0, 7, 0, 0, 0, 0, 0);
        settle();
        check("lu_stallF", stallF, 1);
        check("lu_stallD", stallD, 1);
        check("lu_flushE", flushE, 1);
        check("lu_stallE", stallE, 0);
        step();
        settle();
        check("lu_once", stallF, 0);
        check("lu_stallCnt", stallCnt, 1);
        step();
        settle();
        check("lu_fwdB", forwardBE, 1);
        nop();
        repeat (3) step();

        // lui x3 then reader; x0 writer then x0 reader
        issue(0, 0, 3, 1, 0, 0, 1);
        step();
        issue(3, 0, 0, 0, 0, 0, 0);
        step();
        settle();
        check("fwd_lui", forwardAE, 3);
        issue(0, 0, 0, 1, 0, 0, 0);
        step();
        issue(0, 0, 0, 0, 0, 0, 0);
        step();
        settle();
        check("fwd_x0", forwardAE, 0);
        nop();
        repeat (3) step();

        // load-use and redirect in the same cycle
        issue(0, 0, 9, 1, 1, 1, 0);
        step();
        issue(9, 0, 0, 0, 0, 0, 0);
        redirectE = 1'b1;
        settle();
        check("rd_flushD", flushD, 1);
        check("rd_flushE", flushE, 1);
        check("rd_stallF", stallF, 0);
        step();
        redirectE = 1'b0;
        nop();
        settle();
        check("rd_flushCnt", flushCnt, 1);
        check("rd_stallCnt", stallCnt, 1);
        repeat (3) step();

        // memory wait with TIMEOUT=2
        issue(0, 0, 10, 1, 1, 1, 0);
        step();
        nop();
        step();
        memReady = 1'b0;
        settle();
        check("mw1_stallF", stallF, 1);
        check("mw1_stallM", stallM, 1);
        check("mw1_flushE", flushE, 0);
        check("mw1_memErr", memErr, 0);
        step();
        settle();
        check("mw2_stallE", stallE, 1);
        check("mw2_memErr", memErr, 0);
        step();
        settle();
        check("mw3_stallD", stallD, 1);
        check("mw3_flushD", flushD, 0);
        check("mw3_memErr", memErr, 1);
        check("mw3_stallCnt", stallCnt, 3);

        // async reset in the middle of the wait
        rst = 1'b0;
        #1;
        check("ar_stallF", stallF, 0);
        check("ar_stallM", stallM, 0);
        check("ar_memErr", memErr, 0);
        check("ar_stallCnt", stallCnt, 0);
        check("ar_flushCnt", flushCnt, 0);
        step();
        rst = 1'b1;
        step();
        settle();
        check("post_nostall", stallF, 0);
        check("post_stallCnt", stallCnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
